// File: rtl/pre_if_stage.sv
// Pre-IF fetch unit: next-PC generation, one outstanding request on an sram-like inst port, and
// redirect/cancel handling. Optional build macro PFS_CANCEL_CNT_EN adds a dropped-response counter.
module pre_if_stage_chk (
    input logic clk,
    input logic reset,
    input logic inst_data_ok,
    input logic wait_data
);
    // A response may only arrive while a fetch is outstanding.
    assert property (@(posedge clk) disable iff (reset) inst_data_ok |-> wait_data);
endmodule

module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXC_PC   = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [33:0] exc_eret_bus,
    input  logic [33:0] br_bus,
    input  logic        fs_allowin,
    output logic        pfs_to_fs_valid,
    output logic [63:0] pfs_to_fs_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
`ifdef PFS_CANCEL_CNT_EN
    ,
    output logic [31:0] perf_cancel_cnt
`endif
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] next_pc_q, next_pc_d, req_pc_q, req_pc_d, br_tgt_q, br_tgt_d;
    logic        cancel_q, cancel_d, br_pend_q, br_pend_d;
    logic [63:0] hold_q, hold_d;

    logic        flush_s, redir_s, br_ds_s, data_in_s, capture_s, addr_hs_s;
    logic [31:0] redir_pc_s;

    // A flush carries either an exception or an eret; a delay-slot-passed branch behaves as a flush.
    assign flush_s    = flush & (exc_eret_bus[33] | exc_eret_bus[32]);
    assign redir_s    = flush_s | (br_bus[32] & br_bus[33]);
    assign redir_pc_s = flush_s ? (exc_eret_bus[33] ? EXC_PC : exc_eret_bus[31:0]) : br_bus[31:0];
    assign br_ds_s    = br_bus[32] & ~br_bus[33] & ~flush_s;
    assign data_in_s  = (state_q == S_WAIT_DATA) & inst_data_ok;
    assign capture_s  = data_in_s & ~cancel_q & ~redir_s;
    assign addr_hs_s  = inst_req & inst_addr_ok;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            next_pc_q <= RESET_PC;
            req_pc_q  <= 32'd0;
            br_tgt_q  <= 32'd0;
            cancel_q  <= 1'b0;
            br_pend_q <= 1'b0;
            hold_q    <= 64'd0;
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            req_pc_q  <= req_pc_d;
            br_tgt_q  <= br_tgt_d;
            cancel_q  <= cancel_d;
            br_pend_q <= br_pend_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = addr_hs_s ? S_WAIT_DATA : S_WAIT_ADDR;
            S_WAIT_ADDR: state_d = addr_hs_s ? S_WAIT_DATA : S_WAIT_ADDR;
            S_WAIT_DATA: begin
                if (inst_data_ok) begin
                    state_d = (cancel_q | redir_s) ? S_IDLE : S_HOLD;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_HOLD:      state_d = (redir_s | fs_allowin) ? S_IDLE : S_HOLD;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next-PC, pending-branch and cancel bookkeeping.
    always_comb begin
        next_pc_d = next_pc_q;
        br_pend_d = br_pend_q;
        br_tgt_d  = br_tgt_q;
        cancel_d  = cancel_q;
        req_pc_d  = (state_q == S_IDLE) ? next_pc_q : req_pc_q;
        hold_d    = capture_s ? {inst_rdata, req_pc_q} : hold_q;
        if (redir_s) begin
            next_pc_d = redir_pc_s;
            br_pend_d = 1'b0;
            // A response landing in the redirect cycle is dropped on the spot, so no cancel is left armed.
            cancel_d  = (state_q != S_HOLD) & ~data_in_s;
        end else if (data_in_s) begin
            cancel_d  = 1'b0;
        end else begin
            cancel_d  = cancel_q;
        end
        if (redir_s) begin
            br_pend_d = 1'b0;
        end else if (br_ds_s) begin
            if ((state_q == S_HOLD) | capture_s) begin
                next_pc_d = br_bus[31:0];
                br_pend_d = 1'b0;
            end else begin
                br_pend_d = 1'b1;
                br_tgt_d  = br_bus[31:0];
            end
        end else if (capture_s) begin
            next_pc_d = br_pend_q ? br_tgt_q : (req_pc_q + 32'd4);
            br_pend_d = 1'b0;
        end else begin
            br_pend_d = br_pend_q;
        end
    end

    // Request and IF-side outputs decoded from the current state.
    always_comb begin
        inst_req  = 1'b0;
        inst_addr = req_pc_q;
        case (state_q)
            S_IDLE: begin
                inst_req  = ~reset;
                inst_addr = next_pc_q;
            end
            S_WAIT_ADDR: inst_req = ~reset;
            default:     inst_req = 1'b0;
        endcase
    end

    assign pfs_to_fs_valid = (state_q == S_HOLD);
    assign pfs_to_fs_bus   = hold_q;

`ifdef PFS_CANCEL_CNT_EN
    logic        drop_s;
    logic [31:0] cancel_cnt_q;
    assign drop_s = (data_in_s & (cancel_q | redir_s)) | ((state_q == S_HOLD) & redir_s);

    // Saturating count of responses thrown away by redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt_q <= 32'd0;
        end else if (drop_s && (cancel_cnt_q != 32'hffffffff)) begin
            cancel_cnt_q <= cancel_cnt_q + 32'd1;
        end else begin
            cancel_cnt_q <= cancel_cnt_q;
        end
    end
    assign perf_cancel_cnt = cancel_cnt_q;
`endif

    pre_if_stage_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .inst_data_ok (inst_data_ok),
        .wait_data    (state_q == S_WAIT_DATA)
    );
endmodule

// File: tb/tb_pre_if_stage.sv
// Randomised scoreboard bench for pre_if_stage; a fetch-level reference model predicts request
// addresses and delivered {inst,pc} pairs, and a negedge monitor compares them.
module tb_pre_if_stage;
    localparam logic [31:0] RST_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_PC = 32'hbfc00380;
    localparam int PH_NEED = 0;
    localparam int PH_OUT  = 1;
    localparam int PH_HELD = 2;

    logic        clk = 1'b0;
    logic        reset, flush, fs_allowin, inst_addr_ok, inst_data_ok;
    logic [33:0] exc_eret_bus, br_bus;
    logic [31:0] inst_rdata, inst_addr;
    logic        pfs_to_fs_valid, inst_req;
    logic [63:0] pfs_to_fs_bus;
`ifdef PFS_CANCEL_CNT_EN
    logic [31:0] perf_cancel_cnt;
`endif

    always #5 clk = ~clk;

    pre_if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .exc_eret_bus    (exc_eret_bus),
        .br_bus          (br_bus),
        .fs_allowin      (fs_allowin),
        .pfs_to_fs_valid (pfs_to_fs_valid),
        .pfs_to_fs_bus   (pfs_to_fs_bus),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata)
`ifdef PFS_CANCEL_CNT_EN
        ,
        .perf_cancel_cnt (perf_cancel_cnt)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;

    // Reference model: one fetch at a time, tracked as a token with an address and a doomed flag.
    int          m_ph;
    bit          m_doomed, m_brp;
    logic [31:0] m_npc, m_faddr, m_brt;
    int unsigned m_cnt;
    logic [31:0] addr_q[$];
    logic [63:0] dlv_q[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a0ff0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic start_fetch();
        m_ph    = PH_NEED;
        m_faddr = m_npc;
        addr_q.push_back(m_npc);
    endtask

    task automatic model_reset();
        m_npc = RST_PC; m_brp = 1'b0; m_doomed = 1'b0; m_cnt = 0;
        addr_q.delete(); dlv_q.delete();
        start_fetch();
    endtask

    task automatic model_step();
        int ph0;
        bit fl, red;
        logic [31:0] tgt;
        ph0 = m_ph;
        fl  = flush && (exc_eret_bus[33] || exc_eret_bus[32]);
        red = fl || (br_bus[32] && br_bus[33]);
        tgt = fl ? (exc_eret_bus[33] ? EXC_PC : exc_eret_bus[31:0]) : br_bus[31:0];
        if (red) begin
            m_npc = tgt;
            m_brp = 1'b0;
            if (ph0 == PH_HELD) begin
                void'(dlv_q.pop_back());
                m_cnt++;
                start_fetch();
                return;
            end
            m_doomed = 1'b1;
        end else if (br_bus[32]) begin
            if (ph0 == PH_HELD) m_npc = br_bus[31:0];
            else begin
                m_brp = 1'b1;
                m_brt = br_bus[31:0];
            end
        end
        if (ph0 == PH_NEED) begin
            if (inst_addr_ok) m_ph = PH_OUT;
        end else if (ph0 == PH_OUT) begin
            if (inst_data_ok) begin
                if (m_doomed) begin
                    m_doomed = 1'b0;
                    m_cnt++;
                    start_fetch();
                end else begin
                    dlv_q.push_back({inst_rdata, m_faddr});
                    m_ph  = PH_HELD;
                    m_npc = m_brp ? m_brt : m_faddr + 32'd4;
                    m_brp = 1'b0;
                end
            end
        end else if (fs_allowin) begin
            start_fetch();
        end
    endtask

    // One clock of stimulus; redirects never coincide with IF accepting.
    task automatic cyc(input bit fl, input bit ex, input logic [31:0] epc, input bit br, input bit bd,
                       input logic [31:0] tgt, input bit aok, input bit dok, input bit allow);
        flush        = fl;
        exc_eret_bus = fl ? {ex, ~ex, epc} : 34'd0;
        br_bus       = {bd, br, tgt};
        inst_addr_ok = aok;
        inst_data_ok = dok && (m_ph == PH_OUT);
        inst_rdata   = mem_f(m_faddr);
        fs_allowin   = (fl || br) ? 1'b0 : allow;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle(input bit aok, input bit dok, input bit allow);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, aok, dok, allow);
    endtask

    task automatic wait_ph(input int ph);
        int n = 0;
        while (m_ph != ph && n < 50) begin
            idle(ph != PH_NEED, 1'b1, ph != PH_HELD);
            n++;
        end
        if (m_ph != ph) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_phase: phase %0d not reached, still %0d", ph, m_ph);
        end
    endtask

    task automatic run(input int n, input int paok, input int pdok, input int pall, input int pred);
        for (int i = 0; i < n; i++) begin
            bit red, fl, ex, br, bd;
            int k;
            logic [31:0] tgt;
            red = ($urandom_range(99) < pred);
            k   = $urandom_range(4);
            tgt = ($urandom_range(7) == 0) ? 32'hfffffff8 : ($urandom() & 32'hfffffffc);
            fl  = red && (k <= 1 || k == 4);
            ex  = (k == 0);
            br  = red && (k >= 2);
            bd  = (k == 2) ? 1'b1 : (k == 3) ? 1'b0 : 1'($urandom_range(1));
            cyc(fl, ex, tgt, br, bd, tgt ^ 32'h00000100,
                $urandom_range(99) < paok, $urandom_range(99) < pdok, $urandom_range(99) < pall);
        end
    endtask

    // Monitor: compares every DUT-presented request and delivery against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("inst_req", inst_req, m_ph == PH_NEED);
                if (inst_req && inst_addr_ok) begin
                    if (addr_q.size() == 0) chk("req_unexpected", 1, 0);
                    else chk("inst_addr", inst_addr, addr_q.pop_front());
                end
                chk("valid", pfs_to_fs_valid, m_ph == PH_HELD);
                if (pfs_to_fs_valid) begin
                    if (dlv_q.size() == 0) chk("valid_unexpected", 1, 0);
                    else begin
                        chk("fs_bus", pfs_to_fs_bus, dlv_q[0]);
                        if (fs_allowin) void'(dlv_q.pop_front());
                    end
                end
`ifdef PFS_CANCEL_CNT_EN
                chk("cancel_cnt", perf_cancel_cnt, m_cnt);
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        reset = 1'b1; flush = 1'b0; exc_eret_bus = 34'd0; br_bus = 34'd0; fs_allowin = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
        m_ph = PH_NEED; m_faddr = 32'd0; m_npc = RST_PC; m_brt = 32'd0; m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", inst_req, 0);
        chk("rst_valid", pfs_to_fs_valid, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Back-to-back fetches with immediate handshakes.
        repeat (12) idle(1'b1, 1'b1, 1'b1);
        // IF stalls for five cycles while an instruction is held.
        wait_ph(PH_HELD);
        repeat (5) idle(1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b1);

        // Exception flush while waiting for data: response dropped, refetch from EXC_PC.
        wait_ph(PH_NEED);
        idle(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b1, 1'b1);
        chk("exc_addr", inst_addr, EXC_PC);
        chk("exc_req", inst_req, 1);
`ifdef PFS_CANCEL_CNT_EN
        chk("exc_cnt", perf_cancel_cnt, 32'd1);
`endif

        // Branch with delay slot still to fetch, raised while the request waits for acceptance.
        wait_ph(PH_NEED);
        x = m_faddr;
        idle(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h80001000, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        chk("ds_pc", pfs_to_fs_bus[31:0], x);
        idle(1'b0, 1'b0, 1'b1);
        chk("br_addr", inst_addr, 32'h80001000);

        // Branch whose delay slot is already past: held instruction dropped.
        wait_ph(PH_HELD);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h80002000, 1'b0, 1'b0, 1'b0);
        chk("bd1_addr", inst_addr, 32'h80002000);
        chk("bd1_valid", pfs_to_fs_valid, 0);

        // Eret flush and branch in the same cycle: the flush wins.
        wait_ph(PH_HELD);
        cyc(1'b1, 1'b0, 32'h80000040, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        chk("eret_addr", inst_addr, 32'h80000040);
        wait_ph(PH_HELD);
        chk("eret_pc", pfs_to_fs_bus[31:0], 32'h80000040);
        idle(1'b0, 1'b0, 1'b1);
        chk("eret_next", inst_addr, 32'h80000044);
`ifdef PFS_CANCEL_CNT_EN
        chk("drop_cnt", perf_cancel_cnt, 32'd3);
`endif

        // PC wraps past the top of the address space.
        wait_ph(PH_HELD);
        cyc(1'b1, 1'b0, 32'hfffffffc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_ph(PH_HELD);
        idle(1'b0, 1'b0, 1'b1);
        chk("wrap_addr", inst_addr, 32'h00000000);

        run(1000, 70, 60, 70, 8);
        run(1000, 100, 100, 100, 15);
        run(1000, 30, 30, 40, 25);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
